// File: rtl/single_port_ram.sv
// Single-port synchronous RAM: one address, write or read each cycle,
// registered read data. Optional write-through via SPRAM_WRITE_THROUGH_EN.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low (clears Data_read only)
//   wr_rd_ena  1 = write mem[addr], 0 = read mem[addr]
//   addr       word address, Addr_Width bits
//   Data_write write word, Data_Width bits
//   Data_read  registered read word, Data_Width bits
//
// Build option:
//   SPRAM_WRITE_THROUGH_EN defined   -> write-first, Data_read follows writes
//   SPRAM_WRITE_THROUGH_EN undefined -> no-change, Data_read held on writes
module single_port_ram #(
   parameter int Data_Width = 8,
   parameter int Addr_Width = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_rd_ena,
   input  logic [Addr_Width-1:0] addr,
   input  logic [Data_Width-1:0] Data_write,
   output logic [Data_Width-1:0] Data_read
);

   localparam int Depth = 2 ** Addr_Width;

   // Power-up contents are zero; reset never touches the array.
   logic [Data_Width-1:0] mem [Depth] = '{default: '0};
   logic [Data_Width-1:0] rd_q = '0;

   logic wr_en;
   assign wr_en = rst_n & wr_rd_ena;

   // Array kept in its own process, free of reset, so it maps to RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= Data_write;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q <= '0;
      end else if (wr_rd_ena) begin
`ifdef SPRAM_WRITE_THROUGH_EN
         rd_q <= Data_write;
`else
         rd_q <= rd_q;
`endif
      end else begin
         rd_q <= mem[addr];
      end
   end

   assign Data_read = rd_q;

endmodule

// File: tb/tb_single_port_ram.sv
// Directed self-checking bench for single_port_ram (8-bit x 4 words).
// Expected values are hand-computed for the selected build mode.
module tb_single_port_ram;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_rd_ena = 1'b0;
   logic [1:0] addr = '0;
   logic [7:0] Data_write = '0;
   logic [7:0] Data_read;

   int n_run = 0;
   int n_fail = 0;

   single_port_ram #(
      .Data_Width(8),
      .Addr_Width(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_rd_ena (wr_rd_ena),
      .addr      (addr),
      .Data_write(Data_write),
      .Data_read (Data_read)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Present inputs, take one rising edge, settle 1 ns past it.
   task automatic cyc(input logic r, input logic we,
                      input logic [1:0] a, input logic [7:0] d);
      rst_n      = r;
      wr_rd_ena  = we;
      addr       = a;
      Data_write = d;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] wdat [4];
   logic [7:0] exp_w;

   initial begin
      wdat[0] = 8'h06;
      wdat[1] = 8'h05;
      wdat[2] = 8'h04;
      wdat[3] = 8'h03;

      // 1: reset then read zeroed array
      cyc(1'b0, 1'b0, 2'd0, 8'h00);
      cyc(1'b0, 1'b0, 2'd0, 8'h00);
      chk("reset", Data_read, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 2'(i), 8'h00);
         chk($sformatf("init_rd%0d", i), Data_read, 8'h00);
      end

      // 2: write 2 cycles each
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b1, 2'(i), wdat[i]);
`ifdef SPRAM_WRITE_THROUGH_EN
            exp_w = wdat[i];
`else
            exp_w = 8'h00;
`endif
            chk($sformatf("wr%0d_%0d", i, k), Data_read, exp_w);
         end
      end

      // 3: read back
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 2'(i), 8'hEE);
         chk($sformatf("rd%0d", i), Data_read, wdat[i]);
      end

      // 4: write then read same address back-to-back
      cyc(1'b1, 1'b1, 2'd2, 8'hA5);
`ifdef SPRAM_WRITE_THROUGH_EN
      exp_w = 8'hA5;
`else
      exp_w = 8'h03;
`endif
      chk("wr_a5_hold", Data_read, exp_w);
      cyc(1'b1, 1'b0, 2'd2, 8'h00);
      chk("rd_a5", Data_read, 8'hA5);

      // 5: reset during a write
      cyc(1'b0, 1'b1, 2'd1, 8'hFF);
      chk("rst_wr", Data_read, 8'h00);
      cyc(1'b1, 1'b0, 2'd1, 8'h00);
      chk("rd_after_rst", Data_read, 8'h05);

      // write after release in default mode must not disturb Data_read
      cyc(1'b1, 1'b1, 2'd3, 8'h03);
`ifdef SPRAM_WRITE_THROUGH_EN
      exp_w = 8'h03;
`else
      exp_w = 8'h05;
`endif
      chk("wr_hold2", Data_read, exp_w);

      // 6: alternate addr 0 / addr 3
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, (i % 2 == 0) ? 2'd0 : 2'd3, 8'h00);
         exp_w = (i % 2 == 0) ? 8'h06 : 8'h03;
         chk($sformatf("alt%0d", i), Data_read, exp_w);
      end

      // inputs changing between edges have no effect
      addr = 2'd0;
      #4;
      addr = 2'd2;
      #4;
      chk("mid_cycle", Data_read, 8'h03);
      cyc(1'b1, 1'b0, 2'd2, 8'h00);
      chk("rd_after_glitch", Data_read, 8'hA5);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
